subservient_periph_mux: RTL and testbench

SUBSERVIENT_PERIPH_MUX -- requirements
Module: subservient_periph_mux

---
 rtl/subservient_periph_pkg.sv | 14 +
 rtl/subservient_periph_timeout.sv | 30 +++
 rtl/subservient_periph_mux.sv | 107 ++++++++++
 tb/tb_subservient_periph_mux.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/subservient_periph_pkg.sv
// Shared definitions for the subservient peripheral mux: FSM encodings and
// default slot count / ack timeout.
package subservient_periph_pkg;

    localparam int unsigned DEFAULT_N_SLAVES = 4;
    localparam int unsigned DEFAULT_TIMEOUT  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/subservient_periph_timeout.sv
// Saturating BUSY-cycle counter; flags expiry on the cycle the count sits at
// TIMEOUT-1 while counting is enabled.
module subservient_periph_timeout
    import subservient_periph_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + CW'(1);
        end
    end

    assign expired = enable && (count == LAST);

endmodule

// File: rtl/subservient_periph_mux.sv
// Single-bit Wishbone slot mux: routes one master transaction to a selected
// peripheral slot and answers itself on bad addresses or a silent slave.
module subservient_periph_mux
    import subservient_periph_pkg::*;
#(
    parameter int unsigned N_SLAVES = DEFAULT_N_SLAVES,
    parameter int unsigned TIMEOUT  = DEFAULT_TIMEOUT
) (
    input  logic                i_wb_clk,
    input  logic                i_wb_rst,
    input  logic [2:0]          i_wb_adr,
    input  logic                i_wb_dat,
    input  logic                i_wb_we,
    input  logic                i_wb_stb,
    output logic                o_wb_rdt,
    output logic                o_wb_ack,
    output logic [N_SLAVES-1:0] o_s_stb,
    output logic                o_s_we,
    output logic                o_s_dat,
    input  logic [N_SLAVES-1:0] i_s_rdt,
    input  logic [N_SLAVES-1:0] i_s_ack,
    output logic                o_timeout_err
);

    state_t     state;
    logic [2:0] sel;
    logic       sel_ack;
    logic       sel_rdt;
    logic       expired;
    logic       adr_valid;

    assign o_s_we    = i_wb_we;
    assign o_s_dat   = i_wb_dat;
    assign adr_valid = ({1'b0, i_wb_adr} < 4'(N_SLAVES));

    // Only the selected slot is looked at, so stray acks elsewhere never matter.
    always_comb begin
        sel_ack = 1'b0;
        sel_rdt = 1'b0;
        o_s_stb = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (sel == 3'(i)) begin
                sel_ack    = i_s_ack[i];
                sel_rdt    = i_s_rdt[i];
                o_s_stb[i] = (state == BUSY);
            end
        end
    end

    subservient_periph_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (i_wb_clk),
        .rst     (i_wb_rst),
        .clear   (state != BUSY),
        .enable  (state == BUSY),
        .expired (expired)
    );

    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            state         <= IDLE;
            sel           <= 3'd0;
            o_wb_ack      <= 1'b0;
            o_wb_rdt      <= 1'b0;
            o_timeout_err <= 1'b0;
        end else begin
            o_wb_ack <= 1'b0;
            o_wb_rdt <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (i_wb_stb) begin
                        if (adr_valid) begin
                            sel   <= i_wb_adr;
                            state <= BUSY;
                        end else begin
                            state         <= RESP;
                            o_wb_ack      <= 1'b1;
                            o_timeout_err <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    // A master abandoning the cycle gets no response at all.
                    if (!i_wb_stb) begin
                        state <= IDLE;
                    end else if (sel_ack) begin
                        state    <= RESP;
                        o_wb_ack <= 1'b1;
                        o_wb_rdt <= sel_rdt;
                    end else if (expired) begin
                        state         <= RESP;
                        o_wb_ack      <= 1'b1;
                        o_timeout_err <= 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_subservient_periph_mux.sv
// Scoreboard bench for subservient_periph_mux with per-slot slave models.
module tb_subservient_periph_mux;

    typedef struct packed {
        logic rdt;
        logic err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] adr = 3'd0;
    logic       dat = 1'b0;
    logic       we  = 1'b0;
    logic       stb = 1'b0;
    logic       wb_rdt;
    logic       wb_ack;
    logic [3:0] s_stb;
    logic       s_we;
    logic       s_dat;
    logic [3:0] s_rdt     = 4'b0000;
    logic [3:0] ack_r     = 4'b0000;
    logic [3:0] force_ack = 4'b0000;
    logic       timeout_err;
    logic       gpio      = 1'b0;

    int   delay [4];
    int   cnt   [4];
    exp_t sb[$];
    int   vectors    = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    subservient_periph_mux #(
        .N_SLAVES (4),
        .TIMEOUT  (16)
    ) dut (
        .i_wb_clk      (clk),
        .i_wb_rst      (rst),
        .i_wb_adr      (adr),
        .i_wb_dat      (dat),
        .i_wb_we       (we),
        .i_wb_stb      (stb),
        .o_wb_rdt      (wb_rdt),
        .o_wb_ack      (wb_ack),
        .o_s_stb       (s_stb),
        .o_s_we        (s_we),
        .o_s_dat       (s_dat),
        .i_s_rdt       (s_rdt),
        .i_s_ack       (ack_r | force_ack),
        .o_timeout_err (timeout_err)
    );

    // Slave models: ack one cycle after `delay` strobed cycles (0 = never ack).
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                ack_r[i] <= 1'b0;
                cnt[i]   <= 0;
            end else if (s_stb[i] && !ack_r[i]) begin
                cnt[i] <= cnt[i] + 1;
                if (delay[i] != 0 && cnt[i] + 1 == delay[i]) ack_r[i] <= 1'b1;
            end else begin
                ack_r[i] <= 1'b0;
                cnt[i]   <= 0;
            end
        end
        if (!rst && s_stb[0] && s_we) gpio <= s_dat;
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every ack cycle must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (wb_ack) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ack_rdt", int'(wb_rdt), int'(e.rdt));
                check("ack_err", int'(timeout_err), int'(e.err));
            end
        end
    end

    task automatic xfer(input string name, input logic [2:0] a, input logic w, input logic d,
                        input logic exp_rdt, input logic exp_err, input int exp_lat,
                        input int exp_stbc, input logic [3:0] exp_stb);
        int cyc;
        int stbc;
        bit got;
        exp_t e;
        e.rdt = exp_rdt;
        e.err = exp_err;
        sb.push_back(e);
        adr  = a;
        we   = w;
        dat  = d;
        stb  = 1'b1;
        cyc  = 0;
        stbc = 0;
        got  = 1'b0;
        while (!got && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (s_stb != 4'b0000) begin
                stbc++;
                if (s_stb != exp_stb) check({name, "_stb_pattern"}, int'(s_stb), int'(exp_stb));
            end
            if (wb_ack) got = 1'b1;
        end
        check({name, "_ack_seen"}, int'(got), 1);
        check({name, "_latency"}, cyc, exp_lat);
        check({name, "_stb_cycles"}, stbc, exp_stbc);
        stb = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) delay[i] = 1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_ack", int'(wb_ack), 0);
        check("rst_rdt", int'(wb_rdt), 0);
        check("rst_err", int'(timeout_err), 0);
        check("rst_stb", int'(s_stb), 0);

        // GPIO write on slot 0, one-cycle-ack slave.
        @(negedge clk);
        s_rdt = 4'b0000;
        xfer("wr0", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3, 2, 4'b0001);
        check("gpio_set", int'(gpio), 1);

        // Read slot 2 with a five-cycle slave, then back-to-back read slot 3.
        @(negedge clk);
        delay[2] = 5;
        s_rdt    = 4'b1100;
        xfer("rd2", 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 7, 6, 4'b0100);
        xfer("b2b3", 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 4, 2, 4'b1000);

        // Stray slot-3 ack ignored; slot-1 ack lands on the timeout cycle and wins.
        @(negedge clk);
        delay[1] = 15;
        s_rdt    = 4'b1010;
        fork
            xfer("race1", 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 17, 16, 4'b0010);
            begin
                repeat (3) @(negedge clk);
                force_ack = 4'b1000;
                @(negedge clk);
                force_ack = 4'b0000;
            end
        join
        @(negedge clk);
        check("race_no_err", int'(timeout_err), 0);

        // Silent slot 1: mux times out after 16 BUSY cycles.
        delay[1] = 0;
        xfer("tmo1", 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 17, 16, 4'b0010);
        @(negedge clk);
        xfer("wr0_sticky", 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 3, 2, 4'b0001);
        check("gpio_clr", int'(gpio), 0);

        // Reset sampled at the end of the second BUSY cycle aborts the read.
        @(negedge clk);
        delay[2] = 0;
        adr = 3'd2;
        we  = 1'b0;
        stb = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        stb = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ack", int'(wb_ack), 0);
        check("abort_rdt", int'(wb_rdt), 0);
        check("abort_err", int'(timeout_err), 0);
        check("abort_stb", int'(s_stb), 0);
        repeat (3) @(negedge clk);
        xfer("post_rst", 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 3, 2, 4'b1000);

        // Master drops strobe mid-BUSY: back to idle silently.
        @(negedge clk);
        adr = 3'd1;
        stb = 1'b1;
        @(negedge clk);
        @(negedge clk);
        stb = 1'b0;
        @(negedge clk);
        check("drop_stb", int'(s_stb), 0);
        check("drop_err", int'(timeout_err), 0);
        repeat (3) @(negedge clk);

        // Unmapped slot answers on the next cycle with an error.
        xfer("bad5", 3'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 4'b0000);
        repeat (4) @(negedge clk);
        check("err_sticky", int'(timeout_err), 1);
        check("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
